// File: rtl/pkt_tx_gen_if.sv
// rtl/pkt_tx_gen_if.sv - transmit word stream between packet generator and MAC FIFO
interface pkt_tx_gen_if;
    logic [63:0] pkt_tx_data;
    logic        pkt_tx_val;
    logic        pkt_tx_sop;
    logic        pkt_tx_eop;
    logic [2:0]  pkt_tx_mod;
    logic        pkt_tx_full;

    modport master (
        output pkt_tx_data,
        output pkt_tx_val,
        output pkt_tx_sop,
        output pkt_tx_eop,
        output pkt_tx_mod,
        input  pkt_tx_full
    );

    modport slave (
        input  pkt_tx_data,
        input  pkt_tx_val,
        input  pkt_tx_sop,
        input  pkt_tx_eop,
        input  pkt_tx_mod,
        output pkt_tx_full
    );
endinterface

// File: rtl/pkt_tx_gen.sv
// rtl/pkt_tx_gen.sv - burst packet generator with counting payload and inter-packet gap
module pkt_tx_gen (
    input  logic         clk_156m25,
    input  logic         reset_156m25_n,
    input  logic         start,
    input  logic [13:0]  cfg_pkt_len,
    input  logic [15:0]  cfg_pkt_count,
    input  logic [7:0]   cfg_gap,
    pkt_tx_gen_if.master tx,
    output logic         busy,
    output logic         done,
    output logic [15:0]  pkts_sent
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  gap_q, gap_d;
    logic [11:0] nwords_q, nwords_d;
    logic [2:0]  last_mod_q, last_mod_d;
    logic [11:0] word_idx_q, word_idx_d;
    logic [15:0] pkt_idx_q, pkt_idx_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [63:0] data_q, data_d;
    logic        val_q, val_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic [2:0]  mod_q, mod_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] pkts_sent_q, pkts_sent_d;

    logic [13:0] eff_len;
    logic [14:0] len_round;
    logic [11:0] cfg_nwords;
    logic        is_last_word;
    logic [7:0]  base_byte;
    logic [7:0]  lane;
    logic [63:0] word_data;

    // Derive per-packet word count from the requested length, minimum one full word
    always_comb begin
        eff_len    = (cfg_pkt_len < 14'd8) ? 14'd8 : cfg_pkt_len;
        len_round  = {1'b0, eff_len} + 15'd7;
        cfg_nwords = len_round[14:3];
    end

    // Build the current payload word: byte k of packet p is p+k, tail lanes of the last word zeroed
    always_comb begin
        is_last_word = (word_idx_q == nwords_q - 12'd1);
        base_byte    = pkt_idx_q[7:0] + {word_idx_q[4:0], 3'b000};
        word_data    = 64'd0;
        lane         = 8'd0;
        for (int j = 0; j < 8; j++) begin
            lane = base_byte + 8'(j);
            if (is_last_word && (last_mod_q != 3'd0) && (3'(j) >= last_mod_q)) begin
                lane = 8'd0;
            end
            word_data[63-8*j -: 8] = lane;
        end
    end

    // Burst sequencing: IDLE latches config, SEND issues words under backpressure, GAP idles
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        gap_d       = gap_q;
        nwords_d    = nwords_q;
        last_mod_d  = last_mod_q;
        word_idx_d  = word_idx_q;
        pkt_idx_d   = pkt_idx_q;
        gap_cnt_d   = gap_cnt_q;
        busy_d      = busy_q;
        pkts_sent_d = pkts_sent_q;
        data_d      = 64'd0;
        val_d       = 1'b0;
        sop_d       = 1'b0;
        eop_d       = 1'b0;
        mod_d       = 3'd0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d     = cfg_pkt_count;
                    gap_d       = cfg_gap;
                    nwords_d    = cfg_nwords;
                    last_mod_d  = eff_len[2:0];
                    word_idx_d  = 12'd0;
                    pkt_idx_d   = 16'd0;
                    pkts_sent_d = 16'd0;
                    busy_d      = 1'b1;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (pkt_idx_q == count_q) begin
                    // All packets issued (or none requested): finish one cycle after the last eop
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (!tx.pkt_tx_full) begin
                    val_d  = 1'b1;
                    sop_d  = (word_idx_q == 12'd0);
                    data_d = word_data;
                    if (is_last_word) begin
                        eop_d       = 1'b1;
                        mod_d       = last_mod_q;
                        pkts_sent_d = pkts_sent_q + 16'd1;
                        pkt_idx_d   = pkt_idx_q + 16'd1;
                        word_idx_d  = 12'd0;
                        // The final packet skips the gap and goes straight to completion
                        if ((pkt_idx_q + 16'd1 != count_q) && (gap_q != 8'd0)) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        word_idx_d = word_idx_q + 12'd1;
                    end
                end
            end
            ST_GAP: begin
                // Gap counts raw cycles; backpressure is irrelevant here
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q == 8'd1) begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state_q     <= ST_IDLE;
            count_q     <= 16'd0;
            gap_q       <= 8'd0;
            nwords_q    <= 12'd0;
            last_mod_q  <= 3'd0;
            word_idx_q  <= 12'd0;
            pkt_idx_q   <= 16'd0;
            gap_cnt_q   <= 8'd0;
            data_q      <= 64'd0;
            val_q       <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            mod_q       <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pkts_sent_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            nwords_q    <= nwords_d;
            last_mod_q  <= last_mod_d;
            word_idx_q  <= word_idx_d;
            pkt_idx_q   <= pkt_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            data_q      <= data_d;
            val_q       <= val_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            mod_q       <= mod_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pkts_sent_q <= pkts_sent_d;
        end
    end

    assign tx.pkt_tx_data = data_q;
    assign tx.pkt_tx_val  = val_q;
    assign tx.pkt_tx_sop  = sop_q;
    assign tx.pkt_tx_eop  = eop_q;
    assign tx.pkt_tx_mod  = mod_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pkts_sent      = pkts_sent_q;

endmodule
